// File: rtl/vector_control_recomp_if.sv
// Buffer RAM port bundle: one read address plus one write port (wren/waddr/wdata).
// The producer side uses the master modport; RAM models use the slave modport.
interface vector_control_recomp_if #(
  parameter int AW     = 6,
  parameter int DATA_W = 32
);
  logic              wren;
  logic [AW-1:0]     waddr;
  logic [AW-1:0]     raddr;
  logic [DATA_W-1:0] wdata;

  modport master (output wren, output waddr, output raddr, output wdata);
  modport slave  (input wren, input waddr, input raddr, input wdata);
endinterface

// File: rtl/vector_control_recomp.sv
// Digit-plane recomposition: per lane sum digit_d << (d*digit_bits), then one conditional
// reduction by p. Optional macro RECOMP_SIGNED_DIGIT_EN selects signed (balanced) digits.
module vector_control_recomp #(
  parameter int         WIDTH               = 3,
  parameter int         E                   = 2,
  parameter int         FSIZE               = 16,
  parameter int         MAX_DIGITS          = 8,
  parameter int         BUFFER_READ_LATENCY = 1,
  parameter int         RD_LAT              = BUFFER_READ_LATENCY + 1,
  parameter logic [3:0] VECTOR_OPERATION_RECOMP = 4'd6,
  localparam int        DW                  = $clog2(MAX_DIGITS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_vector,
  input  logic [3:0]             operation,
  input  logic [FSIZE-1:0]       p,
  input  logic [5:0]             digit_bits,
  input  logic [DW:0]            num_digits,
  output logic                   vector_working,
  output logic                   vector_done,
  vector_control_recomp_if.master ram_inputs_op1,
  input  logic [E*FSIZE-1:0]     op1,
  vector_control_recomp_if.master ram_inputs_out,
  output logic [1:0]             dbg_state_o
);

`ifdef RECOMP_SIGNED_DIGIT_EN
  localparam int ACC_W = FSIZE + 2;
`else
  localparam int ACC_W = FSIZE + 1;
`endif
  localparam int SH_W = DW + 6;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_DRAIN = 2'd2} state_e;

  typedef struct packed {
    logic             valid;
    logic [DW-1:0]    dig;
    logic             first;
    logic             last;
    logic [WIDTH-1:0] row;
  } tag_t;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   row_q, row_d;
  logic [DW-1:0]      dig_q, dig_d;
  logic [DW:0]        nd_q, nd_d;
  logic [FSIZE-1:0]   p_q, p_d;
  logic [5:0]         db_q, db_d;
  logic               working_q, working_d;
  logic               done_q, done_d;
  logic               wren_q, wren_d;
  logic [WIDTH-1:0]   waddr_q, waddr_d;
  logic [E*FSIZE-1:0] wdata_q, wdata_d;
  logic [ACC_W-1:0]   acc_q [E];
  logic [ACC_W-1:0]   acc_d [E];
  tag_t               tag_q [RD_LAT];
  tag_t               issue_tag, ret;
  logic               dig_last, row_last;

  assign dig_last = ({1'b0, dig_q} == nd_q - (DW+1)'(1));
  assign row_last = &row_q;

  always_comb begin
    issue_tag       = '0;
    issue_tag.valid = (state_q == S_ISSUE);
    issue_tag.dig   = dig_q;
    issue_tag.first = (dig_q == '0);
    issue_tag.last  = dig_last;
    issue_tag.row   = row_q;
  end

  assign ret = tag_q[RD_LAT-1];

  // Handshake: a start is taken only in IDLE; vector_working is high from the cycle after
  // the start through the final write, and drops in the single cycle vector_done pulses.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    dig_d     = dig_q;
    nd_d      = nd_q;
    p_d       = p_q;
    db_d      = db_q;
    working_d = working_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_vector && operation == VECTOR_OPERATION_RECOMP) begin
          if (num_digits == '0) begin
            done_d = 1'b1;
          end else begin
            nd_d      = (num_digits > (DW+1)'(MAX_DIGITS)) ? (DW+1)'(MAX_DIGITS) : num_digits;
            p_d       = p;
            db_d      = digit_bits;
            row_d     = '0;
            dig_d     = '0;
            working_d = 1'b1;
            state_d   = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (dig_last) begin
          dig_d = '0;
          row_d = row_q + WIDTH'(1);
          if (row_last) state_d = S_DRAIN;
        end else begin
          dig_d = dig_q + DW'(1);
        end
      end
      S_DRAIN: begin
        if (wren_q && (&waddr_q)) begin
          state_d   = S_IDLE;
          working_d = 1'b0;
          done_d    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    logic [SH_W-1:0]  sh;
    logic [ACC_W-1:0] ext, term, sum, red, pe;
`ifdef RECOMP_SIGNED_DIGIT_EN
    logic [6:0]       amt;
    logic [ACC_W-1:0] tmp;
    amt = '0;
    tmp = '0;
`endif
    acc_d   = acc_q;
    wren_d  = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    sh      = SH_W'(ret.dig) * SH_W'(db_q);
    pe      = ACC_W'(p_q);
    ext     = '0;
    term    = '0;
    sum     = '0;
    red     = '0;
    if (ret.valid) begin
      for (int i = 0; i < E; i++) begin
`ifdef RECOMP_SIGNED_DIGIT_EN
        ext = ACC_W'(op1[i*FSIZE +: FSIZE]);
        if (db_q != '0 && {1'b0, db_q} < 7'(ACC_W)) begin
          amt = 7'(ACC_W) - {1'b0, db_q};
          tmp = ext << amt;
          ext = $unsigned($signed(tmp) >>> amt);
        end
`else
        ext = ACC_W'(op1[i*FSIZE +: FSIZE]);
`endif
        term = (sh >= SH_W'(FSIZE)) ? '0 : (ext << sh);
        sum  = (ret.first ? '0 : acc_q[i]) + term;
        acc_d[i] = sum;
`ifdef RECOMP_SIGNED_DIGIT_EN
        if (sum[ACC_W-1])   red = sum + pe;
        else if (sum >= pe) red = sum - pe;
        else                red = sum;
`else
        red = (sum >= pe) ? sum - pe : sum;
`endif
        if (ret.last) wdata_d[i*FSIZE +: FSIZE] = red[FSIZE-1:0];
      end
      if (ret.last) begin
        wren_d  = 1'b1;
        waddr_d = ret.row;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      dig_q     <= '0;
      nd_q      <= '0;
      p_q       <= '0;
      db_q      <= '0;
      working_q <= 1'b0;
      done_q    <= 1'b0;
      wren_q    <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      for (int i = 0; i < E; i++) acc_q[i] <= '0;
      for (int k = 0; k < RD_LAT; k++) tag_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      dig_q     <= dig_d;
      nd_q      <= nd_d;
      p_q       <= p_d;
      db_q      <= db_d;
      working_q <= working_d;
      done_q    <= done_d;
      wren_q    <= wren_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      for (int i = 0; i < E; i++) acc_q[i] <= acc_d[i];
      tag_q[0] <= issue_tag;
      for (int k = 1; k < RD_LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  assign vector_working       = working_q;
  assign vector_done          = done_q;
  assign dbg_state_o          = state_q;
  assign ram_inputs_op1.raddr = {dig_q, row_q};
  assign ram_inputs_op1.wren  = 1'b0;
  assign ram_inputs_op1.waddr = '0;
  assign ram_inputs_op1.wdata = '0;
  assign ram_inputs_out.wren  = wren_q;
  assign ram_inputs_out.waddr = waddr_q;
  assign ram_inputs_out.wdata = wdata_q;
  assign ram_inputs_out.raddr = '0;

endmodule

// File: tb/tb_vector_control_recomp.sv
// Directed bench for vector_control_recomp: plane memory model with 2-cycle read latency,
// write monitor against an expected row table, and start/reset edge cases.
module tb_vector_control_recomp;
  localparam int         WIDTH      = 3;
  localparam int         E          = 2;
  localparam int         FSIZE      = 16;
  localparam int         MAX_DIGITS = 8;
  localparam int         DW         = 3;
  localparam int         ROWS       = 1 << WIDTH;
  localparam logic [3:0] OP_RECOMP  = 4'd6;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start_vector = 1'b0;
  logic [3:0]         operation = '0;
  logic [FSIZE-1:0]   p = '0;
  logic [5:0]         digit_bits = '0;
  logic [DW:0]        num_digits = '0;
  logic               vector_working, vector_done;
  logic [E*FSIZE-1:0] op1, rd_stage;
  logic [1:0]         dbg_state;

  logic [E*FSIZE-1:0] mem     [0:(1<<(DW+WIDTH))-1];
  logic [E*FSIZE-1:0] exp_mem [0:ROWS-1];

  int tests_run = 0;
  int tests_failed = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int exp_row = 0;

  vector_control_recomp_if #(.AW(DW+WIDTH), .DATA_W(E*FSIZE)) ram_op1_if ();
  vector_control_recomp_if #(.AW(WIDTH),    .DATA_W(E*FSIZE)) ram_out_if ();

  vector_control_recomp #(
    .WIDTH(WIDTH), .E(E), .FSIZE(FSIZE), .MAX_DIGITS(MAX_DIGITS),
    .BUFFER_READ_LATENCY(1), .VECTOR_OPERATION_RECOMP(OP_RECOMP)
  ) dut (
    .clk(clk), .rst(rst), .start_vector(start_vector), .operation(operation),
    .p(p), .digit_bits(digit_bits), .num_digits(num_digits),
    .vector_working(vector_working), .vector_done(vector_done),
    .ram_inputs_op1(ram_op1_if), .op1(op1), .ram_inputs_out(ram_out_if),
    .dbg_state_o(dbg_state)
  );

  // clock / reset-free clock generation
  always #5 clk = ~clk;

  // plane memory: raddr -> op1 in two clocks
  always @(posedge clk) begin
    rd_stage <= mem[ram_op1_if.raddr];
    op1      <= rd_stage;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every write must be the next row with the expected lanes
  always @(negedge clk) begin
    if (ram_out_if.wren === 1'b1) begin
      check("waddr", 64'(ram_out_if.waddr), 64'(exp_row));
      check("wdata", 64'(ram_out_if.wdata), 64'(exp_mem[exp_row[WIDTH-1:0]]));
      exp_row++;
      wr_cnt++;
    end
    if (vector_done === 1'b1) begin
      done_cnt++;
      check("working_low_at_done", 64'(vector_working), 64'd0);
    end
  end

  task automatic set_plane(input int d, input logic [FSIZE-1:0] v);
    for (int r = 0; r < ROWS; r++) mem[d*ROWS + r] = {E{v}};
  endtask

  task automatic set_exp(input logic [FSIZE-1:0] v);
    for (int r = 0; r < ROWS; r++) exp_mem[r] = {E{v}};
  endtask

  task automatic clear_counts();
    wr_cnt = 0;
    done_cnt = 0;
    exp_row = 0;
  endtask

  task automatic start_job(input logic [3:0] op, input logic [FSIZE-1:0] pp,
                           input logic [5:0] db, input logic [DW:0] nd);
    @(negedge clk);
    operation = op;
    p = pp;
    digit_bits = db;
    num_digits = nd;
    start_vector = 1'b1;
    @(negedge clk);
    start_vector = 1'b0;
  endtask

  task automatic finish_job(input string tag);
    for (int c = 0; c < 400 && done_cnt == 0; c++) @(negedge clk);
    check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
    check({tag, "_write_count"}, 64'(wr_cnt), 64'(ROWS));
    @(negedge clk);
    check({tag, "_done_pulse_low"}, 64'(vector_done), 64'd0);
    check({tag, "_state_idle"}, 64'(dbg_state), 64'd0);
  endtask

  task automatic run_job(input string tag, input logic [FSIZE-1:0] pp,
                         input logic [5:0] db, input logic [DW:0] nd);
    clear_counts();
    start_job(OP_RECOMP, pp, db, nd);
    check({tag, "_working"}, 64'(vector_working), 64'd1);
    finish_job(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1<<(DW+WIDTH)); i++) mem[i] = '0;
    set_exp(16'h0);
    repeat (3) @(negedge clk);
    check("rst_working", 64'(vector_working), 64'd0);
    check("rst_done", 64'(vector_done), 64'd0);
    check("rst_wren", 64'(ram_out_if.wren), 64'd0);
    check("rst_raddr", 64'(ram_op1_if.raddr), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("op1_port_wren", 64'(ram_op1_if.wren), 64'd0);

    // basic: 3 + 2<<4 + 1<<8 = 0x123
    set_plane(0, 16'h3); set_plane(1, 16'h2); set_plane(2, 16'h1);
    set_exp(16'h0123);
    run_job("basic", 16'h1001, 6'd4, 4'd3);

`ifndef RECOMP_SIGNED_DIGIT_EN
    // 0xF5 < 0x100 passes through; 0x105 reduces to 0x005
    set_plane(0, 16'h5); set_plane(1, 16'hF);
    set_exp(16'h00F5);
    run_job("condsub_below", 16'h0100, 6'd4, 4'd2);
    set_plane(1, 16'h10);
    set_exp(16'h0005);
    run_job("condsub_above", 16'h0100, 6'd4, 4'd2);
`else
    // -1 + 0 is negative, so p is added: 0x61 - 1 = 0x60
    set_plane(0, 16'hF); set_plane(1, 16'h0);
    set_exp(16'h0060);
    run_job("signed_neg", 16'h0061, 6'd4, 4'd2);
`endif

    // plane 2 shifts by 16 >= FSIZE and drops out: 0x34 + 0x12<<8 = 0x1234
    set_plane(0, 16'h34); set_plane(1, 16'h12); set_plane(2, 16'h7);
    set_exp(16'h1234);
    run_job("shift_overflow", 16'hFFFF, 6'd8, 4'd3);

    // row/lane dependent: lane i of row r = r + (i+1)*16
    for (int r = 0; r < ROWS; r++) begin
      mem[0*ROWS + r] = {E{16'(r)}};
      mem[1*ROWS + r] = {16'h2, 16'h1};
      exp_mem[r]      = {16'(r + 32), 16'(r + 16)};
    end
    run_job("row_lane_pattern", 16'h1001, 6'd4, 4'd2);

    // single digit: 0x1A5 reduced once by 0x100
    set_plane(0, 16'h01A5);
    set_exp(16'h00A5);
    run_job("one_digit", 16'h0100, 6'd16, 4'd1);

    // num_digits 9 clamps to 8: sum of 4^d for d<8 = 0x5555
    for (int d = 0; d < MAX_DIGITS; d++) set_plane(d, 16'h1);
    set_exp(16'h5555);
    run_job("clamp", 16'hFFFF, 6'd2, 4'd9);

    // num_digits 0: done next cycle, nothing else
    clear_counts();
    start_job(OP_RECOMP, 16'h1001, 6'd4, 4'd0);
    check("nd0_done", 64'(vector_done), 64'd1);
    check("nd0_working", 64'(vector_working), 64'd0);
    repeat (5) @(negedge clk);
    check("nd0_writes", 64'(wr_cnt), 64'd0);
    check("nd0_done_count", 64'(done_cnt), 64'd1);

    // wrong operation: start ignored
    clear_counts();
    start_job(4'd3, 16'h1001, 6'd4, 4'd3);
    check("badop_working", 64'(vector_working), 64'd0);
    repeat (30) @(negedge clk);
    check("badop_writes", 64'(wr_cnt), 64'd0);
    check("badop_done", 64'(done_cnt), 64'd0);

    // second start mid-ISSUE must not disturb the running job
    set_plane(0, 16'h3); set_plane(1, 16'h2); set_plane(2, 16'h1);
    set_exp(16'h0123);
    clear_counts();
    start_job(OP_RECOMP, 16'h1001, 6'd4, 4'd3);
    repeat (3) @(negedge clk);
    check("restart_in_issue", 64'(dbg_state), 64'd1);
    operation = OP_RECOMP; p = 16'h0007; digit_bits = 6'd8; num_digits = 4'd2;
    start_vector = 1'b1;
    @(negedge clk);
    start_vector = 1'b0;
    finish_job("restart_ignored");

    // reset ten cycles into ISSUE: immediate abort, no more writes or done
    clear_counts();
    start_job(OP_RECOMP, 16'h1001, 6'd4, 4'd3);
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    wr_cnt = 0;
    done_cnt = 0;
    #1;
    check("abort_working", 64'(vector_working), 64'd0);
    check("abort_wren", 64'(ram_out_if.wren), 64'd0);
    check("abort_raddr", 64'(ram_op1_if.raddr), 64'd0);
    check("abort_state", 64'(dbg_state), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_writes", 64'(wr_cnt), 64'd0);
    check("abort_done", 64'(done_cnt), 64'd0);
    run_job("after_abort", 16'h1001, 6'd4, 4'd3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
